// File: rtl/i281_pkg.sv
// i281_pkg: shared widths, NOOP word and opcode constants for the i281 datapath.
//   PC_W      : program counter width (PC[PC_W-1] selects the code bank)
//   INSTR_W   : instruction word width
//   CNT_W     : fetched-instruction counter width
//   NOOP_WORD : instruction presented while no word has been fetched
package i281_pkg;
    localparam int PC_W       = 5;
    localparam int INSTR_W    = 16;
    localparam int CNT_W      = 16;
    localparam int BANK_WORDS = 2 ** (PC_W - 1);

    localparam logic [INSTR_W-1:0] NOOP_WORD = 16'h0000;

    localparam logic [3:0] OP_NOOP   = 4'b0000;
    localparam logic [3:0] OP_INPUTC = 4'b0001;
    localparam logic [3:0] OP_INPUTD = 4'b0010;
    localparam logic [3:0] OP_MOVE   = 4'b0011;
    localparam logic [3:0] OP_LOADI  = 4'b0100;
    localparam logic [3:0] OP_ADD    = 4'b0101;
    localparam logic [3:0] OP_ADDI   = 4'b0110;
    localparam logic [3:0] OP_SUB    = 4'b0111;
    localparam logic [3:0] OP_SUBI   = 4'b1000;
    localparam logic [3:0] OP_LOAD   = 4'b1001;
    localparam logic [3:0] OP_LOADF  = 4'b1010;
    localparam logic [3:0] OP_STORE  = 4'b1011;
    localparam logic [3:0] OP_STOREF = 4'b1100;
    localparam logic [3:0] OP_SHIFT  = 4'b1101;
    localparam logic [3:0] OP_JUMP   = 4'b1110;
    localparam logic [3:0] OP_BRANCH = 4'b1111;
endpackage

// File: rtl/i281_code_mux.sv
// i281_code_mux: combinational word select from the two flattened code ROM banks.
//   code_low  : words 0..15, word k at [16k+15:16k]
//   code_high : words 16..31, same packing
//   pc        : word address; top bit picks the bank
//   word      : selected instruction word
module i281_code_mux
    import i281_pkg::*;
(
    input  logic [BANK_WORDS*INSTR_W-1:0] code_low,
    input  logic [BANK_WORDS*INSTR_W-1:0] code_high,
    input  logic [PC_W-1:0]               pc,
    output logic [INSTR_W-1:0]            word
);
    logic [INSTR_W-1:0] low_w  [BANK_WORDS];
    logic [INSTR_W-1:0] high_w [BANK_WORDS];

    for (genvar k = 0; k < BANK_WORDS; k++) begin : g_unpack
        assign low_w[k]  = code_low[k*INSTR_W +: INSTR_W];
        assign high_w[k] = code_high[k*INSTR_W +: INSTR_W];
    end

    assign word = pc[PC_W-1] ? high_w[pc[PC_W-2:0]] : low_w[pc[PC_W-2:0]];
endmodule

// File: rtl/i281_fetch_unit.sv
// i281_fetch_unit: program counter plus one-entry registered instruction output with valid/ready.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   code_low, code_high        : flattened code ROM banks
//   run, step                  : free-run enable, single-fetch pulse while halted
//   redirect_valid/redirect_pc : branch/jump target, overrides fetching
//   instr_ready                : decode accepts the presented word
//   instr_valid/out/pc         : presented word and its address
//   pc                         : next address to fetch
//   fetch_count                : saturating count of accepted handshakes
module i281_fetch_unit
    import i281_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BANK_WORDS*INSTR_W-1:0] code_low,
    input  logic [BANK_WORDS*INSTR_W-1:0] code_high,
    input  logic                          run,
    input  logic                          step,
    input  logic                          redirect_valid,
    input  logic [PC_W-1:0]               redirect_pc,
    input  logic                          instr_ready,
    output logic                          instr_valid,
    output logic [INSTR_W-1:0]            instr_out,
    output logic [PC_W-1:0]               instr_pc,
    output logic [PC_W-1:0]               pc,
    output logic [CNT_W-1:0]              fetch_count
);
    logic [PC_W-1:0]    pc_q, pc_d, instr_pc_q, instr_pc_d;
    logic [INSTR_W-1:0] instr_out_q, instr_out_d, word;
    logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;
    logic               instr_valid_q, instr_valid_d, step_pending_q, step_pending_d;
    logic               slot_free, fetch_en, accept;

    i281_code_mux u_code_mux (
        .code_low  (code_low),
        .code_high (code_high),
        .pc        (pc_q),
        .word      (word)
    );

    always_comb begin
        slot_free      = !instr_valid_q || instr_ready;
        accept         = instr_valid_q && instr_ready;
        fetch_en       = slot_free && (run || step_pending_q) && !redirect_valid;
        // redirect flushes the held word even when it is being accepted this cycle
        pc_d           = redirect_valid ? redirect_pc : fetch_en ? pc_q + PC_W'(1) : pc_q;
        instr_valid_d  = redirect_valid ? 1'b0 : fetch_en ? 1'b1 : accept ? 1'b0 : instr_valid_q;
        instr_out_d    = fetch_en ? word : instr_out_q;
        instr_pc_d     = fetch_en ? pc_q : instr_pc_q;
        // a step while one is already pending is dropped; step is meaningless while running
        step_pending_d = (fetch_en && !run) ? 1'b0 : (step && !run) ? 1'b1 : step_pending_q;
        fetch_count_d  = (accept && fetch_count_q != '1) ? fetch_count_q + CNT_W'(1) : fetch_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= '0;
            instr_valid_q  <= 1'b0;
            instr_out_q    <= NOOP_WORD;
            instr_pc_q     <= '0;
            fetch_count_q  <= '0;
            step_pending_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            instr_valid_q  <= instr_valid_d;
            instr_out_q    <= instr_out_d;
            instr_pc_q     <= instr_pc_d;
            fetch_count_q  <= fetch_count_d;
            step_pending_q <= step_pending_d;
        end
    end

    assign pc          = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_count = fetch_count_q;
endmodule

// File: doc/i281_fetch_unit.md
Name: i281_fetch_unit

Overview:
- Instruction fetch stage that consumes the two 16-word code ROM banks (low bank = words 0-15, high bank = words 16-31) and presents one registered instruction at a time to the decode stage.
- Owns the 5-bit program counter and a one-entry output register with a valid/ready handshake.
- Supports redirects from the branch/jump logic, plus run/single-step control for board debugging.

Parameters:
- PC_W, 5, program counter width; 2^PC_W words total, PC[4] selects bank.
- INSTR_W, 16, instruction word width.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- code_low  in  256  low bank flattened; word k at [16k+15:16k].
- code_high  in  256  high bank flattened, same packing.
- run  in  1  1 = free-running fetch; 0 = halted.
- step  in  1  single-cycle pulse; permits exactly one fetch while run=0.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  5  target word address.
- instr_ready  in  1  decode accepts instr_out this cycle.
- instr_valid  out  1  instr_out/instr_pc hold a valid fetched word.
- instr_out  out  16  fetched instruction.
- instr_pc  out  5  address of instr_out.
- pc  out  5  next address to fetch.
- fetch_count  out  16  number of accepted handshakes, saturating.

Behaviour:
- Reset (async, rst_n=0): pc=0, instr_valid=0, instr_out=16'h0000 (NOOP), instr_pc=0, fetch_count=0, step_pending=0. All state updates thereafter occur on the rising edge of clk.
- Word select is combinational: word = pc[4] ? code_high[pc[3:0]] : code_low[pc[3:0]].
- Slot free: slot_free = !instr_valid || instr_ready.
- Fetch enable: fetch_en = slot_free && (run || step_pending) && !redirect_valid.
- On fetch_en:
  - instr_out <= word; instr_pc <= pc; instr_valid <= 1.
  - pc <= pc+1, wrapping 31 -> 0.
  - If run=0, step_pending <= 0.
- Latency: one cycle from pc to instr_out.
- Back-to-back throughput is one word per cycle while instr_ready=1.
- Hold: instr_valid=1 && instr_ready=0 -> instr_out, instr_pc, instr_valid and pc all hold.
- Redirect has highest priority:
  - pc <= redirect_pc; instr_valid <= 0 (flush the held word even if not yet accepted).
  - No fetch occurs in the redirect cycle. First word from the target is valid one cycle later, provided the fetch conditions hold.
- Accept handshake (instr_valid && instr_ready) in the same cycle as redirect_valid: the handshake completes and counts, and the output still flushes.
- step: a rising-level pulse with run=0 sets step_pending. It is cleared by the next fetch.
  - Further step pulses while step_pending=1 are ignored (no queuing).
  - step is ignored when run=1.
- run falling to 0: the currently held valid word remains until accepted; no further fetch.
- fetch_count increments on every instr_valid && instr_ready and saturates at 16'hFFFF.
- Banks are treated as stable static inputs; no caching of code words.

Decomposition:
- Shared package i281_pkg holds:
  - PC_W, INSTR_W;
  - NOOP_WORD = 16'h0000;
  - opcode constants (JUMP = 4'b1110, etc.), used by the downstream decoder and the bench.
- One natural sub-module, i281_code_mux: purely combinational 32:1 word select from the two flattened banks by pc. The rest (pc, output register, step logic, counter) stays in the top.

Test Plan:
- Reset then run=1, instr_ready=1, pc forced via redirect to 16, high bank loaded with 5401/E0F6/8005 at words 0-2 -> instr_out 16'h5401, 16'hE0F6, 16'h8005 on successive cycles, instr_pc 16, 17, 18.
- Wrap: redirect to 31, run -> instr_pc 31 then 0; second word is code_low word 0.
- Backpressure: instr_ready=0 for 3 cycles after first valid -> instr_out/instr_pc/pc unchanged, fetch_count unchanged. Release -> counts resume, no word skipped or duplicated.
- Redirect while valid and stalled: redirect_pc=18 -> next cycle instr_valid=0, pc=18. Following cycle instr_out=16'h8005, instr_pc=18.
- Single-step: run=0, three step pulses spaced 4 cycles apart -> exactly three fetches. A second step pulse during a stall yields no extra fetch.
- Async reset mid-stream: assert rst_n=0 between clock edges -> instr_valid, pc and fetch_count clear immediately, without waiting for a clock edge.
